// File: rtl/bram_stream_if.sv
// BRAM read port plus AXI-Stream master channel for the BRAM stream reader.
interface bram_stream_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic                  bram_en;
  logic                  bram_regce;
  logic [DATA_WIDTH-1:0] bram_dout;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output bram_addr, bram_en, bram_regce, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  bram_dout, m_axis_tready
  );

  modport slave (
    input  bram_addr, bram_en, bram_regce, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output bram_dout, m_axis_tready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Fixed-latency BRAM reader feeding an AXI-Stream master through a credit-guarded skid FIFO.
// Optional BRAM_READER_LOOP_EN: replay the window continuously until stop.
module bram_stream_reader #(
  parameter int DATA_WIDTH   = 18,
  parameter int BRAM_DEPTH   = 16,
  parameter int READ_LATENCY = 3,
  parameter int FIFO_DEPTH   = 4,
  localparam int AW          = $clog2(BRAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   length,
  input  logic          stop,
  output logic          busy,
  output logic          done,
  bram_stream_if.master bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                state, state_nx;
  logic [AW-1:0]         addr, addr_inc;
  logic [AW:0]           remaining;
`ifdef BRAM_READER_LOOP_EN
  logic [AW-1:0]         base_addr;
  logic [AW:0]           win_len;
`endif
  logic [READ_LATENCY-1:0] vld_pipe, lst_pipe;
  ent_t                  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic                  issue, issue_last, push, pop, credit_ok, drained, zero_done, accept;
  ent_t                  head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push       = vld_pipe[READ_LATENCY-1];
  assign pop        = (fifo_cnt != '0) && bus.m_axis_tready;
  assign drained    = (fifo_cnt == '0) && (vld_pipe == '0);
  assign accept     = (state == S_IDLE) && start && (length != '0);
  assign issue_last = (remaining == (AW+1)'(1));
  assign addr_inc   = (addr == AW'(BRAM_DEPTH - 1)) ? '0 : addr + AW'(1);
  // Credit counts the word leaving this cycle, so steady tready=1 sustains one issue per cycle.
  assign credit_ok  = ($countones(vld_pipe) + int'(fifo_cnt) - int'(pop)) < FIFO_DEPTH;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
`ifdef BRAM_READER_LOOP_EN
      S_RUN:   if (stop) state_nx = S_DRAIN;
`else
      S_RUN:   if (stop || (issue && issue_last)) state_nx = S_DRAIN;
`endif
      S_DRAIN: if (drained) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    issue = (state == S_RUN) && (remaining != '0) && credit_ok;
    done  = zero_done || ((state == S_DRAIN) && drained);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
`ifdef BRAM_READER_LOOP_EN
      base_addr <= '0;
      win_len   <= '0;
`endif
      vld_pipe  <= '0;
      lst_pipe  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= (state == S_IDLE) && start && (length == '0);
      if (accept) begin
        addr      <= start_addr;
        remaining <= length;
`ifdef BRAM_READER_LOOP_EN
        base_addr <= start_addr;
        win_len   <= length;
`endif
      end else if (issue) begin
        if (issue_last) begin
`ifdef BRAM_READER_LOOP_EN
          addr      <= base_addr;
          remaining <= win_len;
`else
          addr      <= addr_inc;
          remaining <= '0;
`endif
        end else begin
          addr      <= addr_inc;
          remaining <= remaining - (AW+1)'(1);
        end
      end
      vld_pipe[0] <= issue;
      lst_pipe[0] <= issue && issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: tdata/tlast are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{last: lst_pipe[READ_LATENCY-1], data: bus.bram_dout};
  end

  assign head              = fifo_mem[rd_ptr];
  assign bus.m_axis_tvalid = (fifo_cnt != '0);
  assign bus.m_axis_tdata  = bus.m_axis_tvalid ? head.data : '0;
  assign bus.m_axis_tlast  = bus.m_axis_tvalid && head.last;
  assign bus.bram_en       = issue;
  assign bus.bram_addr     = addr;
  assign bus.bram_regce    = 1'b1;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader against a 3-stage BRAM model holding mem[i]=i+100.
module tb_bram_stream_reader;
  localparam int DW = 18, D = 16, L = 3, FD = 4, AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, stop, busy, done;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;

  bram_stream_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  bram_stream_reader #(.DATA_WIDTH(DW), .BRAM_DEPTH(D), .READ_LATENCY(L), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .stop(stop), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rd_pipe [L];
  always @(posedge clk) begin
    if (bus.bram_en) rd_pipe[0] <= DW'(bus.bram_addr) + DW'(100);
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.bram_dout = rd_pipe[L-1];

  typedef struct { logic [DW-1:0] d; logic l; } exp_t;
  exp_t sb[$];
  int   hs_cyc[$];
  int   cyc = 0, nchk = 0, nerr = 0;
  int   nhs = 0, nlast = 0, done_cnt = 0, done_cyc = 0;
  int   iss = 0, acc = 0, max_out = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      iss = 0; acc = 0;
    end else begin
      if (bus.bram_en) iss++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        exp_t e;
        acc++; nhs++; hs_cyc.push_back(cyc);
        if (bus.m_axis_tlast) nlast++;
        chk("sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("tdata", 32'(bus.m_axis_tdata), 32'(e.d));
          chk("tlast", 32'(bus.m_axis_tlast), 32'(e.l));
        end
      end
      if (iss - acc > max_out) max_out = iss - acc;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_win(input int a, input int len);
    for (int k = 0; k < len; k++) begin
      exp_t e;
      e.d = DW'(100 + ((a + k) % D));
      e.l = (k == len - 1);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input int a, input int len);
    start = 1'b1; start_addr = AW'(a); length = (AW+1)'(len);
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(1); stop = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0 = done_cnt, k = 0;
    while (done_cnt == n0 && k < 300) begin tick(1); k++; end
    chk(tag, 32'(done_cnt > n0), 1);
  endtask

  task automatic wait_hs(input int n, input string tag);
    int k = 0;
    while (nhs < n && k < 300) begin tick(1); k++; end
    chk(tag, 32'(nhs >= n), 1);
  endtask

  task automatic run_basic(input string tag);
    int c0, h0;
    hs_cyc.delete();
    h0 = nhs;
    push_win(2, 4);
    c0 = cyc;
    pulse_start(2, 4);
    wait_done({tag, "_done"});
    chk({tag, "_count"}, 32'(nhs - h0), 4);
    if (hs_cyc.size() == 4) begin
      chk({tag, "_first_lat"}, 32'(hs_cyc[0] - c0), 5);
      chk({tag, "_b2b"}, 32'(hs_cyc[3] - hs_cyc[0]), 3);
      chk({tag, "_done_lat"}, 32'(done_cyc - hs_cyc[3]), 1);
    end
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin
    int h0, t0, d0, c0, got;
    rst = 1'b1; start = 1'b0; stop = 1'b0; start_addr = '0; length = '0;
    bus.m_axis_tready = 1'b1;
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(bus.bram_en), 0);
    chk("rst_addr", 32'(bus.bram_addr), 0);
    chk("rst_regce", 32'(bus.bram_regce), 1);
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("rst_tlast", 32'(bus.m_axis_tlast), 0);
    chk("rst_tdata", 32'(bus.m_axis_tdata), 0);
    rst = 1'b0;
    tick(2);

    run_basic("t1");

    // Zero-length window and stop while idle
    h0 = nhs; c0 = cyc;
    pulse_start(5, 0);
    wait_done("zl_done");
    chk("zl_done_lat", 32'(done_cyc - c0), 1);
    chk("zl_busy", 32'(busy), 0);
    chk("zl_no_words", 32'(nhs - h0), 0);
    d0 = done_cnt;
    pulse_stop();
    tick(4);
    chk("idle_stop_busy", 32'(busy), 0);
    chk("idle_stop_done", 32'(done_cnt - d0), 0);

    // Backpressure stall after the second word
    h0 = nhs; max_out = 0;
    push_win(0, 8);
    pulse_start(0, 8);
    wait_hs(h0 + 2, "t2_hs2");
    bus.m_axis_tready = 1'b0;
    tick(10);
    chk("t2_en_stalled", 32'(bus.bram_en), 0);
    chk("t2_tvalid_held", 32'(bus.m_axis_tvalid), 1);
    bus.m_axis_tready = 1'b1;
    wait_done("t2_done");
    chk("t2_count", 32'(nhs - h0), 8);
    chk("t2_outstanding", 32'(max_out <= FD), 1);
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // Address wrap; second start while busy must be ignored
    h0 = nhs;
    push_win(14, 4);
    pulse_start(14, 4);
    tick(1);
    pulse_start(3, 5);
    wait_done("t3_done");
    tick(8);
    chk("t3_count", 32'(nhs - h0), 4);
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // Stop mid-window
    h0 = nhs; t0 = nlast;
    push_win(0, 8);
    pulse_start(0, 8);
    wait_hs(h0 + 2, "t4_hs2");
    pulse_stop();
    wait_done("t4_done");
    got = nhs - h0;
    chk("t4_partial", 32'(got > 2 && got < 8), 1);
    chk("t4_no_tlast", 32'(nlast - t0), 0);
    chk("t4_busy", 32'(busy), 0);
    sb.delete();

    // Reset mid-stream
    h0 = nhs;
    push_win(0, 8);
    pulse_start(0, 8);
    wait_hs(h0 + 3, "t5_hs3");
    bus.m_axis_tready = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_en", 32'(bus.bram_en), 0);
    sb.delete();
    bus.m_axis_tready = 1'b1;
    tick(4);
    run_basic("t5b");

    // Window replay vs single pass
    h0 = nhs; t0 = nlast;
`ifdef BRAM_READER_LOOP_EN
    push_win(0, 3); push_win(0, 3); push_win(0, 3); push_win(0, 3);
    pulse_start(0, 3);
    wait_hs(h0 + 7, "t6_hs7");
    pulse_stop();
    wait_done("t6_done");
    got = nhs - h0;
    chk("t6_loop_count", 32'(got >= 7 && got < 12), 1);
    chk("t6_loop_tlast", 32'(nlast - t0), 32'(got / 3));
    sb.delete();
`else
    push_win(0, 3);
    pulse_start(0, 3);
    wait_done("t6_done");
    chk("t6_count", 32'(nhs - h0), 3);
    chk("t6_tlast", 32'(nlast - t0), 1);
`endif
    chk("t6_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
